// File: rtl/clkdiv_seq_ctrl_if.sv
// Control/status bundle for clkdiv_seq_ctrl.
//   master : config/control side (drives en, div_req, div_val)
//   slave  : divider controller (drives ack/busy/err and the divided clock)
// Signals:
//   en          run request
//   div_req     divisor change request (pulse or level)
//   div_val     requested divisor, valid with div_req
//   div_ack     1-cycle pulse, new divisor in effect
//   busy        accepted change pending
//   err         1-cycle pulse, illegal divisor dropped
//   clk_out     divided clock
//   period_tick high in last clk cycle of each clk_out period
//   running     controller in RUN
interface clkdiv_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             div_req;
  logic [WIDTH-1:0] div_val;
  logic             div_ack;
  logic             busy;
  logic             err;
  logic             clk_out;
  logic             period_tick;
  logic             running;

  modport master (
    output en, div_req, div_val,
    input  div_ack, busy, err, clk_out, period_tick, running
  );

  modport slave (
    input  en, div_req, div_val,
    output div_ack, busy, err, clk_out, period_tick, running
  );
endinterface

// File: rtl/clkdiv_seq_ctrl.sv
// Programmable 50%-duty clock divider with a sequencing controller.
// Divisor changes and start/stop only take effect at clk_out period
// boundaries, so clk_out never glitches or truncates a period.
// Even N uses a posedge flop only; odd N ORs in a negedge flop that
// stretches the high phase by half an input cycle.
// Ports:
//   clk  input clock (control on posedge, one half-cycle flop on negedge)
//   rst  synchronous active-high reset
//   bus  clkdiv_seq_ctrl_if.slave: en, div_req, div_val in;
//        div_ack, busy, err, clk_out, period_tick, running out
module clkdiv_seq_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 3
) (
  input  logic               clk,
  input  logic               rst,
  clkdiv_seq_ctrl_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] DEF_DIV = DEFAULT_DIV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TWO     = ONE << 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] div_reg, div_n;
  logic [WIDTH-1:0] pend_val, pend_n;
  logic             busy_q, busy_n;
  logic             ack_q, ack_n;
  logic             err_q, err_n;
  logic             pos_q, pos_n;
  logic             neg_q;
  logic             boundary;

  // Last input cycle of the current clk_out period.
  assign boundary = (state == RUN) && (cnt == div_reg - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      div_reg  <= DEF_DIV;
      pend_val <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_reg  <= div_n;
      pend_val <= pend_n;
      busy_q   <= busy_n;
      ack_q    <= ack_n;
      err_q    <= err_n;
      pos_q    <= pos_n;
    end
  end

  // Half-cycle delayed copy of pos_q; only used for odd divisors.
  always_ff @(negedge clk) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= pos_q;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_reg;
    pend_n  = pend_val;
    busy_n  = busy_q;
    ack_n   = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.en) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        if (boundary) begin
          // Pending change lands first, then stop is evaluated; both may apply.
          if (busy_q) begin
            div_n  = pend_val;
            busy_n = 1'b0;
            ack_n  = 1'b1;
          end
          cnt_n = '0;
          if (!bus.en) state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Acceptance uses the pre-edge busy, so a request taken on a boundary
    // edge is not applied by that same boundary.
    if (bus.div_req && !busy_q) begin
      if (bus.div_val < TWO) begin
        err_n = 1'b1;
      end else if (state == IDLE) begin
        div_n = bus.div_val;
        ack_n = 1'b1;
      end else begin
        pend_n = bus.div_val;
        busy_n = 1'b1;
      end
    end

    // Registered together with cnt so the high phase tracks the new count.
    pos_n = (state_n == RUN) && (cnt_n < (div_n >> 1));
  end

  assign bus.clk_out     = pos_q | (div_reg[0] & neg_q);
  assign bus.period_tick = boundary;
  assign bus.running     = (state == RUN);
  assign bus.div_ack     = ack_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// Directed testbench for clkdiv_seq_ctrl.
`timescale 1ns/1ps
module tb_clkdiv_seq_ctrl;

  logic clk;
  logic rst;
  clkdiv_seq_ctrl_if #(.WIDTH(4)) bus ();

  clkdiv_seq_ctrl #(.WIDTH(4), .DEFAULT_DIV(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;

  // clk_out edge timing monitor
  time last_rise = 0, last_fall = 0;
  time hi_w = 0, lo_w = 0, per_w = 0;
  int  rises = 0;
  int  runt_cnt = 0;

  always @(posedge bus.clk_out) begin
    lo_w = $time - last_fall;
    per_w = $time - last_rise;
    if (rises > 0 && lo_w < 10) runt_cnt++;
    last_rise = $time;
    rises++;
  end

  always @(negedge bus.clk_out) begin
    hi_w = $time - last_rise;
    if (hi_w < 10) runt_cnt++;
    last_fall = $time;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.en = 1'b0; bus.div_req = 1'b0; bus.div_val = '0;
    repeat (2) tick();
    checks++; if (bus.clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out got %b exp 0", bus.clk_out); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", bus.running); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.div_ack !== 1'b0 || bus.err !== 1'b0 || bus.period_tick !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got ack=%b err=%b tick=%b exp 0 0 0", bus.div_ack, bus.err, bus.period_tick); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_default_run;
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (bus.running !== 1'b1 || bus.clk_out !== 1'b1) begin
          errors++; $display("FAIL start_state got running=%b clk_out=%b exp 1 1", bus.running, bus.clk_out); end
      end
      checks++; if (bus.period_tick !== ((i % 3) == 2)) begin
        errors++; $display("FAIL n3_tick[%0d] got %b exp %b", i, bus.period_tick, ((i % 3) == 2)); end
    end
    checks++; if (hi_w !== 15 || lo_w !== 15 || per_w !== 30) begin
      errors++; $display("FAIL n3_widths got hi=%0t lo=%0t per=%0t exp 15 15 30", hi_w, lo_w, per_w); end
  endtask

  task automatic test_illegal;
    int ticks;
    for (int v = 1; v >= 0; v--) begin
      bus.div_req = 1'b1; bus.div_val = 4'(v);
      tick();
      checks++; if (bus.err !== 1'b1 || bus.div_ack !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL illegal_%0d got err=%b ack=%b busy=%b exp 1 0 0", v, bus.err, bus.div_ack, bus.busy); end
      bus.div_req = 1'b0;
      tick();
      checks++; if (bus.err !== 1'b0 || bus.div_ack !== 1'b0) begin
        errors++; $display("FAIL illegal_%0d_after got err=%b ack=%b exp 0 0", v, bus.err, bus.div_ack); end
    end
    ticks = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.period_tick === 1'b1) ticks++;
    end
    checks++; if (ticks !== 3 || hi_w !== 15 || lo_w !== 15) begin
      errors++; $display("FAIL illegal_keeps_n3 got ticks=%0d hi=%0t lo=%0t exp 3 15 15", ticks, hi_w, lo_w); end
  endtask

  task automatic test_div_change;
    int guard;
    guard = 0;
    while (bus.period_tick !== 1'b1 && guard < 10) begin tick(); guard++; end
    checks++; if (bus.period_tick !== 1'b1) begin errors++; $display("FAIL chg_find_boundary got 0 exp 1"); end
    tick();  // cnt = 0
    bus.div_req = 1'b1; bus.div_val = 4'd4;
    tick();  // accepted, cnt = 1
    bus.div_req = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.div_ack !== 1'b0) begin
      errors++; $display("FAIL chg_accept got busy=%b ack=%b exp 1 0", bus.busy, bus.div_ack); end
    tick();  // cnt = 2, boundary cycle
    checks++; if (bus.busy !== 1'b1 || bus.period_tick !== 1'b1 || bus.div_ack !== 1'b0) begin
      errors++; $display("FAIL chg_pending got busy=%b tick=%b ack=%b exp 1 1 0", bus.busy, bus.period_tick, bus.div_ack); end
    tick();  // boundary applied
    checks++; if (bus.busy !== 1'b0 || bus.div_ack !== 1'b1) begin
      errors++; $display("FAIL chg_ack got busy=%b ack=%b exp 0 1", bus.busy, bus.div_ack); end
    tick();
    checks++; if (bus.div_ack !== 1'b0) begin errors++; $display("FAIL chg_ack_pulse got %b exp 0", bus.div_ack); end
    repeat (9) tick();
    checks++; if (hi_w !== 20 || lo_w !== 20 || per_w !== 40) begin
      errors++; $display("FAIL n4_widths got hi=%0t lo=%0t per=%0t exp 20 20 40", hi_w, lo_w, per_w); end
  endtask

  task automatic test_stop_restart;
    int guard;
    int r0;
    time stop_t;
    bus.div_req = 1'b1; bus.div_val = 4'd5;
    guard = 0;
    do begin tick(); guard++; end while (bus.div_ack !== 1'b1 && guard < 12);
    bus.div_req = 1'b0;
    checks++; if (bus.div_ack !== 1'b1) begin errors++; $display("FAIL stop_ack5 timeout got 0 exp 1"); end
    tick();  // cnt = 1
    bus.en = 1'b0;
    tick(); tick();  // cnt = 2, 3
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL stop_mid_running got %b exp 1", bus.running); end
    tick();  // cnt = 4
    checks++; if (bus.period_tick !== 1'b1 || bus.running !== 1'b1) begin
      errors++; $display("FAIL stop_last got tick=%b running=%b exp 1 1", bus.period_tick, bus.running); end
    tick();
    stop_t = $time - 1;
    checks++; if (bus.running !== 1'b0 || bus.clk_out !== 1'b0) begin
      errors++; $display("FAIL stop_idle got running=%b clk_out=%b exp 0 0", bus.running, bus.clk_out); end
    checks++; if (hi_w !== 25 || (stop_t - last_fall) !== 25) begin
      errors++; $display("FAIL n5_widths got hi=%0t lo=%0t exp 25 25", hi_w, stop_t - last_fall); end
    r0 = rises;
    repeat (5) tick();
    checks++; if (rises !== r0 || bus.clk_out !== 1'b0) begin
      errors++; $display("FAIL stop_quiet got rises=%0d clk_out=%b exp %0d 0", rises, bus.clk_out, r0); end
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.running !== 1'b1 || bus.period_tick !== (i == 4)) begin
        errors++; $display("FAIL restart[%0d] got running=%b tick=%b exp 1 %b", i, bus.running, bus.period_tick, (i == 4)); end
    end
  endtask

  task automatic test_back_to_back;
    int acks;
    int ack_at;
    int ticks;
    int guard;
    // Presently on the N=5 boundary cycle; this request lands on the boundary edge.
    bus.div_req = 1'b1; bus.div_val = 4'd6;
    tick();
    checks++; if (bus.busy !== 1'b1 || bus.div_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b ack=%b exp 1 0", bus.busy, bus.div_ack); end
    bus.div_val = 4'd7;
    repeat (2) begin
      tick();
      checks++; if (bus.err !== 1'b0 || bus.div_ack !== 1'b0) begin
        errors++; $display("FAIL b2b_ignored got err=%b ack=%b exp 0 0", bus.err, bus.div_ack); end
    end
    bus.div_req = 1'b0;
    acks = 0; ack_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.div_ack === 1'b1) begin acks++; ack_at = i; end
    end
    checks++; if (acks !== 1 || ack_at !== 2) begin
      errors++; $display("FAIL b2b_single_ack got count=%0d at=%0d exp 1 2", acks, ack_at); end
    checks++; if (hi_w !== 30 || lo_w !== 30) begin
      errors++; $display("FAIL n6_widths got hi=%0t lo=%0t exp 30 30", hi_w, lo_w); end
    // cnt is 3 here; accept 8 then reset before it can apply.
    bus.div_req = 1'b1; bus.div_val = 4'd8;
    tick();
    bus.div_req = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pend_busy got %b exp 1", bus.busy); end
    tick();
    bus.en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.div_ack !== 1'b0 || bus.running !== 1'b0 || bus.clk_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid got busy=%b ack=%b running=%b clk_out=%b exp 0 0 0 0", bus.busy, bus.div_ack, bus.running, bus.clk_out); end
    tick();
    checks++; if (bus.div_ack !== 1'b0) begin errors++; $display("FAIL rst_no_ack got %b exp 0", bus.div_ack); end
    bus.en = 1'b1;
    ticks = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.period_tick === 1'b1) ticks++;
    end
    checks++; if (ticks !== 3 || hi_w !== 15 || lo_w !== 15) begin
      errors++; $display("FAIL rst_div3 got ticks=%0d hi=%0t lo=%0t exp 3 15 15", ticks, hi_w, lo_w); end
    bus.en = 1'b0;
    guard = 0;
    while (bus.running !== 1'b0 && guard < 10) begin tick(); guard++; end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL stop_timeout got running=1 exp 0"); end
  endtask

  task automatic test_idle_max;
    bus.div_req = 1'b1; bus.div_val = 4'd15;
    tick();
    bus.div_req = 1'b0;
    checks++; if (bus.div_ack !== 1'b1 || bus.busy !== 1'b0 || bus.running !== 1'b0) begin
      errors++; $display("FAIL idle15_ack got ack=%b busy=%b running=%b exp 1 0 0", bus.div_ack, bus.busy, bus.running); end
    tick();
    checks++; if (bus.div_ack !== 1'b0) begin errors++; $display("FAIL idle15_pulse got %b exp 0", bus.div_ack); end
    bus.en = 1'b1;
    repeat (32) tick();
    checks++; if (hi_w !== 75 || lo_w !== 75 || per_w !== 150) begin
      errors++; $display("FAIL n15_widths got hi=%0t lo=%0t per=%0t exp 75 75 150", hi_w, lo_w, per_w); end
    checks++; if (runt_cnt !== 0) begin errors++; $display("FAIL runt_pulses got %0d exp 0", runt_cnt); end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_illegal();
    test_div_change();
    test_stop_restart();
    test_back_to_back();
    test_idle_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
